riscv_dmem_mmio: RTL and testbench
==================================

RISCV_DMEM_MMIO -- requirements
Module: riscv_dmem_mmio

Interface
REQ-001 Parameter: RAM_WORDS, 256, data RAM depth in 32-bit words; power of two.
REQ-002 Parameter: FIFO_DEPTH, 8, sensor sample FIFO depth; power of two, ≤ 15.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 dmem_en  in  1  core data access strobe.
REQ-006 dmem_we  in  1  1 = write, 0 = read; meaningful only with dmem_en=1.
REQ-007 dmem_addr  in  32  byte address from the core; bits [1:0] ignored, word accesses only.
REQ-008 dmem_wdata  in  32  write data.
REQ-009 dmem_rdata  out  32  read data; combinational, valid in the same cycle as the request.
REQ-010 sens_valid  in  1  sensor sample offered.
REQ-011 sens_data  in  16  sensor sample.
REQ-012 sens_ready  out  1  FIFO can accept a sample this cycle.
REQ-013 alert  out  1  anomaly alert flag, written by firmware.

Function
REQ-014 Address decode: 0x0000_0000–(RAM_WORDS*4-1) is RAM; 0x1000_0000–0x1000_001F is MMIO; all other addresses are unmapped.
REQ-015 RAM: word index dmem_addr[log2(RAM_WORDS)+1:2]; write on the clock edge when dmem_en & dmem_we; asynchronous read.
REQ-016 A RAM read in the same cycle as a write to the same word returns the old contents.
REQ-017 Unmapped address: reads return 0; writes are ignored; no state changes.
REQ-018 dmem_rdata is 0 whenever dmem_en=0 or dmem_we=1.
REQ-019 MMIO 0x00 FIFO_DATA (RO): read returns {16'h0, head sample}.
REQ-019a A FIFO_DATA read with the FIFO non-empty pops the head at the clock edge.
REQ-019b A FIFO_DATA read with the FIFO empty returns 0 and does not pop.
REQ-020 MMIO 0x04 STATUS (RO): [3:0] count, [4] empty, [5] full, [6] overflow (sticky), [31:7] 0.
REQ-021 MMIO 0x08 CTRL (WO; reads return 0): write bit0=1 clears overflow; write bit1=1 flushes the FIFO (count, read pointer and write pointer go to 0).
REQ-022 MMIO 0x0C ALERT (RW): bit0 is the alert register and drives the alert output directly; reads return {31'h0, alert}.
REQ-023 MMIO 0x10 CYCLE (RO): free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF → 0; a read returns the pre-edge value.
REQ-024 MMIO offsets 0x14–0x1C: read 0, writes ignored.
REQ-025 sens_ready = !full & !(CTRL write with bit1=1 this cycle).
REQ-026 Push: sens_valid & sens_ready writes sens_data at the write pointer; write pointer wraps modulo FIFO_DEPTH.
REQ-027 Push and pop in the same cycle: both take effect; count is unchanged.
REQ-028 sens_valid=1 while full sets overflow; the sample is dropped.
REQ-029 Overflow set and clear in the same cycle: set wins.
REQ-030 Flush concurrent with a pop: flush wins; the read data still returns the pre-flush head.
REQ-031 No pipeline latency: read data appears in the request cycle; side effects (pop, flush, clear, register write) are visible from the next cycle.

Reset
REQ-032 While resetn=0, the block asynchronously clears: FIFO pointers, count, overflow, alert and CYCLE to 0. sens_ready reads 1 and dmem_rdata follows REQ-018.
REQ-033 RAM and FIFO storage contents are not reset and are undefined until written.
REQ-034 Reset assertion mid-operation discards FIFO contents; the first access after release behaves as after power-on.

Verification
REQ-035 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read 0x0000_0400 → 0. Read 0x2000_0000 → 0.
REQ-036 Push 0x0011, 0x0022, 0x0033 → STATUS = 0x3. Read FIFO_DATA three times → 0x11, 0x22, 0x33. Then STATUS = 0x10 and a further FIFO_DATA read → 0.
REQ-037 Push 8 samples → sens_ready=0 and STATUS = 0x28. Present a 9th sample → STATUS = 0x68. Write CTRL=0x1 → STATUS = 0x28.
REQ-038 With 4 samples held, push and pop in the same cycle → count stays 4 and order is preserved. Write CTRL=0x2 while sens_valid=1 → count 0, sample dropped, sens_ready=0 that cycle.
REQ-039 Write ALERT=0x1 → alert=1. Assert resetn=0 mid-stream with 5 samples held → immediately alert=0, STATUS = 0x10, CYCLE = 0.
REQ-040 Read CYCLE twice 10 cycles apart → difference 10. Force the counter to 0xFFFF_FFFF → next value 0.

Source files
------------

// File: rtl/riscv_dmem_mmio.sv
// Data memory for a small RISC-V core: word RAM plus an MMIO window holding a
// sensor sample FIFO, status/control, a firmware alert flag and a cycle counter.
module riscv_dmem_mmio #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dmem_en,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  input  logic        sens_valid,
  input  logic [15:0] sens_data,
  output logic        sens_ready,
  output logic        alert
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

  logic [31:0]   ram_q  [RAM_WORDS];
  logic [15:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          alert_q, alert_d;
  logic [31:0]   cycle_q, cycle_d;

  logic          rd_s, wr_s, ram_sel_s, mmio_sel_s;
  logic [2:0]    off_s;
  logic [AW-1:0] ram_idx_s;
  logic          empty_s, full_s, pop_s, push_s, flush_s, clr_ovf_s, ovf_set_s, alert_wr_s;
  logic [31:0]   status_s;
  logic          unused_ok;

  assign rd_s       = dmem_en & ~dmem_we;
  assign wr_s       = dmem_en & dmem_we;
  assign ram_sel_s  = (dmem_addr[31:AW+2] == {(30-AW){1'b0}});
  assign mmio_sel_s = (dmem_addr[31:5] == 27'h080_0000);
  assign off_s      = dmem_addr[4:2];
  assign ram_idx_s  = dmem_addr[AW+1:2];

  assign empty_s    = (count_q == 4'd0);
  assign full_s     = (count_q == DEPTH_C);
  assign pop_s      = rd_s & mmio_sel_s & (off_s == 3'd0) & ~empty_s;
  assign flush_s    = wr_s & mmio_sel_s & (off_s == 3'd2) & dmem_wdata[1];
  assign clr_ovf_s  = wr_s & mmio_sel_s & (off_s == 3'd2) & dmem_wdata[0];
  assign alert_wr_s = wr_s & mmio_sel_s & (off_s == 3'd3);
  assign sens_ready = ~full_s & ~flush_s;
  assign push_s     = sens_valid & sens_ready;
  assign ovf_set_s  = sens_valid & full_s;
  assign status_s   = {25'h0, ovf_q, full_s, empty_s, count_q};
  assign alert      = alert_q;
  assign unused_ok  = ^{dmem_addr[1:0], dmem_wdata[31:2]};

  // FIFO bookkeeping; a flush overrides any concurrent push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_s) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = 4'd0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky overflow (set beats clear), alert register and cycle counter
  always_comb begin
    if (ovf_set_s)      ovf_d = 1'b1;
    else if (clr_ovf_s) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
    if (alert_wr_s) alert_d = dmem_wdata[0];
    else            alert_d = alert_q;
    cycle_d = cycle_q + 32'd1;
  end

  // Read data mux; idle or write cycles and unmapped addresses return zero
  always_comb begin
    dmem_rdata = 32'h0;
    if (rd_s && ram_sel_s) begin
      dmem_rdata = ram_q[ram_idx_s];
    end else if (rd_s && mmio_sel_s) begin
      case (off_s)
        3'd0:    dmem_rdata = empty_s ? 32'h0 : {16'h0, fifo_q[rd_ptr_q]};
        3'd1:    dmem_rdata = status_s;
        3'd3:    dmem_rdata = {31'h0, alert_q};
        3'd4:    dmem_rdata = cycle_q;
        default: dmem_rdata = 32'h0;
      endcase
    end else begin
      dmem_rdata = 32'h0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      alert_q  <= 1'b0;
      cycle_q  <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      alert_q  <= alert_d;
      cycle_q  <= cycle_d;
    end
  end

  // Storage arrays carry no reset
  always_ff @(posedge clk) begin
    if (wr_s && ram_sel_s) ram_q[ram_idx_s] <= dmem_wdata;
    if (push_s)            fifo_q[wr_ptr_q] <= sens_data;
  end

endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// Directed self-checking bench for riscv_dmem_mmio.
module tb_riscv_dmem_mmio;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dmem_en, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        sens_valid;
  logic [15:0] sens_data;
  logic        sens_ready, alert;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] c1, c2;

  localparam logic [31:0] FIFO_A  = 32'h1000_0000;
  localparam logic [31:0] STAT_A  = 32'h1000_0004;
  localparam logic [31:0] CTRL_A  = 32'h1000_0008;
  localparam logic [31:0] ALERT_A = 32'h1000_000C;
  localparam logic [31:0] CYC_A   = 32'h1000_0010;

  riscv_dmem_mmio #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .sens_valid(sens_valid), .sens_data(sens_data), .sens_ready(sens_ready),
    .alert(alert)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = a;
    #1 check(tag, dmem_rdata, exp);
    @(negedge clk);
    dmem_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dmem_en = 1'b1; dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d;
    #1 check("rdata_zero_on_write", dmem_rdata, 32'h0);
    @(negedge clk);
    dmem_en = 1'b0; dmem_we = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    sens_valid = 1'b1; sens_data = d;
    @(negedge clk);
    sens_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; dmem_en = 1'b0; dmem_we = 1'b0; dmem_addr = 32'h0;
    dmem_wdata = 32'h0; sens_valid = 1'b0; sens_data = 16'h0;
    @(negedge clk); @(negedge clk);
    check("reset_rdata", dmem_rdata, 32'h0);
    check("reset_ready", {31'h0, sens_ready}, 32'h1);
    check("reset_alert", {31'h0, alert}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    rd(STAT_A, 32'h10, "status_after_reset");

    // RAM and decode
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rw");
    wr(32'h0000_0000, 32'h1234_5678);
    wr(32'h0000_03FC, 32'hCAFE_F00D);
    wr(32'h0000_0400, 32'hFFFF_FFFF);
    rd(32'h0000_0400, 32'h0, "unmapped_ram_end");
    rd(32'h2000_0000, 32'h0, "unmapped_high");
    rd(32'h0000_0000, 32'h1234_5678, "ram_no_alias");
    rd(32'h0000_03FE, 32'hCAFE_F00D, "ram_last_word");

    // Basic FIFO
    push(16'h0011); push(16'h0022); push(16'h0033);
    rd(STAT_A, 32'h3, "status_3");
    rd(FIFO_A, 32'h11, "pop_11");
    rd(FIFO_A, 32'h22, "pop_22");
    rd(FIFO_A, 32'h33, "pop_33");
    rd(STAT_A, 32'h10, "status_empty");
    rd(FIFO_A, 32'h0, "pop_empty");
    rd(STAT_A, 32'h10, "status_still_empty");

    // Full, overflow, clear, set-beats-clear
    for (int i = 1; i <= 8; i++) push(16'(i));
    check("ready_full", {31'h0, sens_ready}, 32'h0);
    rd(STAT_A, 32'h28, "status_full");
    push(16'h0099);
    rd(STAT_A, 32'h68, "status_overflow");
    wr(CTRL_A, 32'h1);
    rd(STAT_A, 32'h28, "status_ovf_cleared");
    sens_valid = 1'b1; sens_data = 16'h00AA;
    wr(CTRL_A, 32'h1);
    sens_valid = 1'b0;
    rd(STAT_A, 32'h68, "ovf_set_wins");
    wr(CTRL_A, 32'h1);
    for (int i = 1; i <= 8; i++) rd(FIFO_A, 32'(i), "drain");
    rd(STAT_A, 32'h10, "status_drained");

    // Concurrent push/pop, then flush with a sample offered
    for (int i = 1; i <= 4; i++) push(16'(16'h00A0 + i));
    sens_valid = 1'b1; sens_data = 16'h00A5;
    rd(FIFO_A, 32'hA1, "pushpop_head");
    sens_valid = 1'b0;
    rd(STAT_A, 32'h4, "pushpop_count");
    for (int i = 2; i <= 5; i++) rd(FIFO_A, 32'(32'hA0 + i), "pushpop_order");
    push(16'h00B0); push(16'h00B1); push(16'h00B2);
    sens_valid = 1'b1; sens_data = 16'h00B3;
    dmem_en = 1'b1; dmem_we = 1'b1; dmem_addr = CTRL_A; dmem_wdata = 32'h2;
    #1 check("flush_ready_low", {31'h0, sens_ready}, 32'h0);
    @(negedge clk);
    dmem_en = 1'b0; dmem_we = 1'b0; sens_valid = 1'b0;
    rd(STAT_A, 32'h10, "status_flushed");
    push(16'h00C1);
    rd(FIFO_A, 32'hC1, "post_flush_push");

    // Alert register and reserved offsets
    wr(ALERT_A, 32'h1);
    check("alert_set", {31'h0, alert}, 32'h1);
    rd(ALERT_A, 32'h1, "alert_read");
    rd(CTRL_A, 32'h0, "ctrl_reads_zero");
    wr(32'h1000_0014, 32'hFFFF_FFFF);
    rd(32'h1000_0014, 32'h0, "reserved_zero");
    rd(32'h1000_0020, 32'h0, "past_mmio_zero");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push(16'(16'h00D0 + i));
    rd(STAT_A, 32'h5, "status_5");
    #2 resetn = 1'b0;
    #1 check("rst_alert", {31'h0, alert}, 32'h0);
    check("rst_ready", {31'h0, sens_ready}, 32'h1);
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = STAT_A;
    #1 check("rst_status", dmem_rdata, 32'h10);
    dmem_addr = CYC_A;
    #1 check("rst_cycle", dmem_rdata, 32'h0);
    dmem_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rd(FIFO_A, 32'h0, "post_reset_empty");

    // Cycle counter distance and wrap
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = CYC_A;
    #1 c1 = dmem_rdata;
    repeat (10) @(negedge clk);
    #1 c2 = dmem_rdata;
    check("cycle_delta", c2 - c1, 32'd10);
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 check("cycle_forced", dmem_rdata, 32'hFFFF_FFFF);
    release dut.cycle_q;
    @(negedge clk);
    #1 check("cycle_wrap", dmem_rdata, 32'h0);
    dmem_en = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
